// File: rtl/transmissor_serial_if.sv
// Handshake bundle between a word source and the serial framer.
// The source owns dado_in/valido_in; the framer answers with pronto_out.
interface transmissor_serial_if #(
  parameter int NBITS_DADO = 4
);
  logic [NBITS_DADO-1:0] dado_in;
  logic                  valido_in;
  logic                  pronto_out;

  modport master (output dado_in, output valido_in, input pronto_out);
  modport slave  (input dado_in, input valido_in, output pronto_out);
endinterface

// File: rtl/transmissor_serial.sv
// Parallel-in, serial-out framed transmitter: start bit, data LSB first,
// optional even parity, stop bit; each bit held CICLOS_POR_BIT cycles.
//
// state        | meaning
// -------------+---------------------------------------------------
// OCIOSO       | idle, line high, pronto_out high, waiting for valido_in
// INICIO       | start bit (line low)
// DADOS        | data bits, line = shift register bit 0
// BIT_PARIDADE | even-parity bit of the latched word
// PARADA       | stop bit (line high), fim_quadro in its last cycle
module transmissor_serial #(
  parameter int NBITS_DADO     = 4,
  parameter int CICLOS_POR_BIT = 1,
  parameter int PARIDADE       = 0
) (
  input  logic                 clk_2,
  input  logic                 reset,
  transmissor_serial_if.slave  bus,
  output logic                 saida_serial,
  output logic                 ocupado,
  output logic                 amostra,
  output logic                 fim_quadro
);

  localparam int CW = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
  localparam int IW = $clog2(NBITS_DADO) + 1;
  localparam logic [CW-1:0] CNT_ULT = CW'(CICLOS_POR_BIT - 1);
  localparam logic [IW-1:0] IDX_ULT = IW'(NBITS_DADO - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    INICIO,
    DADOS,
    BIT_PARIDADE,
    PARADA
  } estado_t;

  estado_t               estado, estado_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [NBITS_DADO-1:0] shift_r, shift_nxt;
  logic                  par_r, par_nxt;
  logic                  pronto_r;
  logic                  saida_nxt, ocupado_nxt, amostra_nxt, fim_nxt;
  logic                  fim_bit;

  assign bus.pronto_out = pronto_r;

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      cnt          <= '0;
      idx          <= '0;
      shift_r      <= '0;
      par_r        <= 1'b0;
      pronto_r     <= 1'b1;
      saida_serial <= 1'b1;
      ocupado      <= 1'b0;
      amostra      <= 1'b0;
      fim_quadro   <= 1'b0;
    end else begin
      estado       <= estado_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      shift_r      <= shift_nxt;
      par_r        <= par_nxt;
      pronto_r     <= (estado_nxt == OCIOSO);
      saida_serial <= saida_nxt;
      ocupado      <= ocupado_nxt;
      amostra      <= amostra_nxt;
      fim_quadro   <= fim_nxt;
    end
  end

  always_comb begin
    estado_nxt = estado;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    shift_nxt  = shift_r;
    par_nxt    = par_r;
    fim_bit    = (cnt == CNT_ULT);

    if (estado != OCIOSO) begin
      cnt_nxt = fim_bit ? '0 : cnt + CW'(1);
    end

    case (estado)
      OCIOSO: begin
        if (bus.valido_in && pronto_r) begin
          estado_nxt = INICIO;
          cnt_nxt    = '0;
          idx_nxt    = '0;
          shift_nxt  = bus.dado_in;
          par_nxt    = ^bus.dado_in;
        end
      end
      INICIO: begin
        if (fim_bit) estado_nxt = DADOS;
      end
      DADOS: begin
        if (fim_bit) begin
          shift_nxt = shift_r >> 1;
          idx_nxt   = idx + IW'(1);
          if (idx == IDX_ULT) begin
            estado_nxt = (PARIDADE != 0) ? BIT_PARIDADE : PARADA;
            idx_nxt    = '0;
          end
        end
      end
      BIT_PARIDADE: begin
        if (fim_bit) estado_nxt = PARADA;
      end
      PARADA: begin
        if (fim_bit) estado_nxt = OCIOSO;
      end
      default: estado_nxt = OCIOSO;
    endcase
  end

  // Outputs are decoded from the next-state values so they leave flops directly.
  always_comb begin
    saida_nxt = 1'b1;
    case (estado_nxt)
      OCIOSO:       saida_nxt = 1'b1;
      INICIO:       saida_nxt = 1'b0;
      DADOS:        saida_nxt = shift_nxt[0];
      BIT_PARIDADE: saida_nxt = par_nxt;
      PARADA:       saida_nxt = 1'b1;
      default:      saida_nxt = 1'b1;
    endcase
    ocupado_nxt = (estado_nxt != OCIOSO);
    amostra_nxt = (estado_nxt == DADOS) && (cnt_nxt == CNT_ULT);
    fim_nxt     = (estado_nxt == PARADA) && (cnt_nxt == CNT_ULT);
  end

endmodule

// File: doc/transmissor_serial.md
# transmissor_serial

Parallel-in, serial-out framed transmitter: accepts an NBITS_DADO word via a valid/ready handshake and drives it onto a single serial line, LSB first, with start bit, optional even parity and stop bit. It is the sending end for the team's 4-bit serial-input shift register. That register shifts in at its MSB and shifts right, so after NBITS_DADO data shifts the first transmitted bit lands in bit 0. On the FPGA top, `dado_in` comes from SWI[7:4], `valido_in` from SWI[0], and `saida_serial` drives a LED or the receiver's serial input.

## Interface
Parameters:
- NBITS_DADO, 4: data word width, ≥1.
- CICLOS_POR_BIT, 1: clk_2 cycles per serial bit, ≥1.
- PARIDADE, 0: 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk_2  input  1  the only clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- dado_in  input  NBITS_DADO  word to transmit; sampled only on acceptance.
- valido_in  input  1  request to send `dado_in`.
- pronto_out  output  1  high only in OCIOSO; a word is accepted on an edge with `valido_in && pronto_out`.
- saida_serial  output  1  serial line; idles high.
- ocupado  output  1  high from the cycle after acceptance until the frame ends.
- amostra  output  1  one-cycle pulse in the last cycle of each data-bit period; serves as the receiver's shift enable.
- fim_quadro  output  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- States:
  - OCIOSO → INICIO on acceptance.
  - INICIO → DADOS.
  - DADOS → PARIDADE (if PARIDADE=1) or PARADA after bit NBITS_DADO-1.
  - PARIDADE → PARADA.
  - PARADA → OCIOSO.
  - Each non-idle state lasts exactly CICLOS_POR_BIT cycles.
- Line value per state:
  - OCIOSO: 1.
  - INICIO: 0.
  - DADOS: shift register bit 0.
  - PARIDADE: XOR of the latched word, so the data bits plus parity bit have even weight.
  - PARADA: 1.
- On acceptance:
  - `dado_in` is copied into the internal shift register.
  - Parity is computed from this copy.
  - Later changes on `dado_in` have no effect on the frame.
- In DADOS, the shift register shifts right by one at the end of each bit period and fills with 0.
- Bit-period counter:
  - Width $clog2(CICLOS_POR_BIT) bits, minimum 1.
  - Counts 0..CICLOS_POR_BIT-1, wraps to 0 on state advance.
- Data-bit index counter: width $clog2(NBITS_DADO)+1; no overflow for any legal NBITS_DADO.
- `valido_in` while not in OCIOSO is ignored, not queued, and does not disturb the frame.
- Outputs are registered: `saida_serial`, `ocupado` and `pronto_out` must be glitch-free.

## Timing
- Reset (asynchronous, takes effect immediately, independent of clk_2):
  - State OCIOSO.
  - saida_serial=1, pronto_out=1, ocupado=0, amostra=0, fim_quadro=0.
  - Shift register and counters cleared.
- Reset released: the block is ready at the first rising edge after release.
- Acceptance edge t: from t+1, saida_serial=0, pronto_out=0, ocupado=1.
- Frame length F = (2 + NBITS_DADO + PARIDADE) × CICLOS_POR_BIT cycles, occupying cycles t+1..t+F.
- Data bit k occupies cycles t+1+(1+k)·C .. t+(2+k)·C, where C = CICLOS_POR_BIT.
- `amostra` is high in the last of those cycles.
- After the frame, at cycle t+F+1:
  - State OCIOSO, pronto_out=1, ocupado=0, line=1.
  - If `valido_in` is held high, the next frame is accepted on that edge.
  - Back-to-back frames are therefore separated by exactly one idle cycle.
- Reset asserted mid-frame: line returns to 1 immediately and the partial frame is abandoned. No `fim_quadro` is produced.

## Test plan
- N=4, C=1, P=0; send 4'b1011 with valido_in high for one cycle: saida_serial over cycles t+1..t+6 = 0,1,1,0,1,1. amostra high at t+2..t+5; fim_quadro at t+6; pronto_out high again at t+7.
- N=4, C=3, P=1; send 4'b0111: each bit lasts 3 cycles. Sequence is start 0, then 1,1,1,0, parity 1, stop 1. F=21; ocupado high for exactly 21 cycles.
- valido_in held high continuously with dado_in toggling between 4'hA and 4'h5 each cycle:
  - Frames carry only the values present at the acceptance edges.
  - Gap between consecutive stop and start bits is exactly one idle cycle.
  - No extra frames are accepted.
- Assert reset at the second data bit of a C=2 frame: saida_serial=1 and pronto_out=1 in the same cycle, with no clock edge needed. A new frame sent after release is correct.
- Loopback into the 4-bit shift register, with `amostra` as its shift enable and the line on its serial input: after fim_quadro, the register equals the sent word for 4'h0, 4'hF, 4'h9 and 4'h6.
- Change dado_in during DADOS: transmitted bits are unchanged. Parity is still computed from the latched word.
